// File: rtl/gmii_fifo_pkg.sv
// Shared constants and types for the GMII receive FIFO writer.
// Tags, FSM states, status flag positions and length limit.
package gmii_fifo_pkg;

  localparam logic [1:0] TAG_IDLE = 2'b00;
  localparam logic [1:0] TAG_STAT = 2'b01;
  localparam logic [1:0] TAG_DATA = 2'b10;
  localparam logic [1:0] TAG_TS   = 2'b11;

  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam int          ST_ERR   = 15;
  localparam int          ST_TRUNC = 14;
  localparam logic [13:0] LEN_MAX  = 14'd16383;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_HUNT,
    S_DATA,
    S_DROP,
    S_TRAIL,
    S_GAPW
  } state_t;

endpackage

// File: rtl/gmii_word_packer.sv
// Packs GMII bytes into BYTES-wide words, first byte in the top lane.
// Exposes the completed word combinationally and the pending partial word.
module gmii_word_packer #(
  parameter int BYTES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_vld,
  input  logic [7:0]         i_byte,
  output logic [8*BYTES-1:0] o_word,
  output logic               o_done,
  output logic [8*BYTES-1:0] o_part,
  output logic [BYTES-1:0]   o_part_mask,
  output logic               o_pend
);

  localparam int IW = $clog2(BYTES);

  logic [IW-1:0]      r_idx;
  logic [8*BYTES-1:0] r_data;
  logic [8*BYTES-1:0] w_next;

  // a byte landing in lane 0 starts a fresh word, so stale lanes read 0
  always_comb begin
    w_next = (r_idx == '0) ? '0 : r_data;
    for (int k = 0; k < BYTES; k++) begin
      if (r_idx == IW'(k)) w_next[8*(BYTES-1-k) +: 8] = i_byte;
    end
  end

  always_comb begin
    o_part_mask = '0;
    for (int k = 0; k < BYTES; k++) begin
      o_part_mask[BYTES-1-k] = (IW'(k) < r_idx);
    end
  end

  assign o_word = w_next;
  assign o_done = i_vld && (r_idx == IW'(BYTES-1));
  assign o_part = r_data;
  assign o_pend = (r_idx != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (i_vld) begin
      r_data <= w_next;
      r_idx  <= o_done ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/gmii2fifo_ts.sv
// GMII receive to FIFO writer: strips preamble, packs bytes, appends
// flush, status, optional timestamp and idle words per frame.
module gmii2fifo_ts
  import gmii_fifo_pkg::*;
#(
  parameter  int BYTES = 2,
  parameter  int TS_EN = 1,
  parameter  int GAP   = 2,
  parameter  int CNT_W = 8,
  localparam int DW    = 2 + BYTES + 8*BYTES
) (
  input  logic             gmii_rx_clk,
  input  logic             sys_rst_n,
  input  logic [63:0]      global_counter,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic [7:0]       gmii_rxd,
  output logic [DW-1:0]    din,
  input  logic             full,
  output logic             wr_en,
  output logic             wr_clk,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int NTS   = (TS_EN != 0) ? 8 / BYTES : 0;
  localparam int TLAST = 1 + NTS;

  state_t             r_st;
  state_t             w_nx;
  logic               r_wr;
  logic [DW-1:0]      r_din;
  logic [CNT_W-1:0]   r_fc;
  logic [CNT_W-1:0]   r_dc;
  logic [63:0]        r_ts;
  logic [13:0]        r_len;
  logic               r_err;
  logic               r_trunc;
  logic               r_dcnt;
  logic [3:0]         r_tidx;
  logic [2:0]         r_gcnt;

  logic               w_sfd;
  logic               w_pk_vld;
  logic [8*BYTES-1:0] w_pk_word;
  logic               w_done;
  logic [8*BYTES-1:0] w_part;
  logic [BYTES-1:0]   w_pmask;
  logic               w_pend;

  logic               w_due;
  logic               w_dword;
  logic               w_lost;
  logic               w_tgo;
  logic [3:0]         w_tsel;
  logic               w_gap_go;
  logic               w_drop_evt;
  logic [1:0]         w_tag;
  logic [BYTES-1:0]   w_mask;
  logic [8*BYTES-1:0] w_data;
  logic [15:0]        w_stat;

  assign wr_clk      = gmii_rx_clk;
  assign wr_en       = r_wr;
  assign din         = r_din;
  assign frame_count = r_fc;
  assign drop_count  = r_dc;

  assign w_pk_vld = (r_st == S_DATA) && gmii_rx_dv;

  gmii_word_packer #(.BYTES(BYTES)) u_pack (
    .i_clk       (gmii_rx_clk),
    .i_rst_n     (sys_rst_n),
    .i_clr       (w_sfd),
    .i_vld       (w_pk_vld),
    .i_byte      (gmii_rxd),
    .o_word      (w_pk_word),
    .o_done      (w_done),
    .o_part      (w_part),
    .o_part_mask (w_pmask),
    .o_pend      (w_pend)
  );

  always_comb begin
    w_nx     = r_st;
    w_sfd    = 1'b0;
    w_dword  = 1'b0;
    w_lost   = 1'b0;
    w_tgo    = 1'b0;
    w_tsel   = r_tidx;
    w_gap_go = 1'b0;
    unique case (r_st)
      S_WAIT_IDLE: if (!gmii_rx_dv) w_nx = S_HUNT;
      S_HUNT: begin
        if (gmii_rx_dv && gmii_rxd == SFD_BYTE) begin
          w_nx  = S_DATA;
          w_sfd = 1'b1;
        end
      end
      S_DATA: begin
        if (gmii_rx_dv) begin
          w_dword = w_done;
          if (w_done && full) begin
            w_lost = 1'b1;
            w_nx   = S_DROP;
          end
        end else begin
          w_tgo  = 1'b1;
          w_tsel = w_pend ? 4'd0 : 4'd1;
        end
      end
      S_DROP: begin
        if (!gmii_rx_dv) begin
          w_tgo  = 1'b1;
          w_tsel = 4'd1;
        end
      end
      S_TRAIL: w_tgo = 1'b1;
      S_GAPW:  w_gap_go = 1'b1;
      default: w_nx = S_WAIT_IDLE;
    endcase
    // a frame still active when the trailer ends cannot be aligned
    if (w_tgo) begin
      if (w_tsel == 4'(TLAST)) begin
        if (GAP != 0)        w_nx = S_GAPW;
        else if (gmii_rx_dv) w_nx = S_WAIT_IDLE;
        else                 w_nx = S_HUNT;
      end else begin
        w_nx = S_TRAIL;
      end
    end
    if (w_gap_go && r_gcnt == 3'(GAP-1)) begin
      w_nx = gmii_rx_dv ? S_WAIT_IDLE : S_HUNT;
    end
  end

  assign w_due = w_dword || w_tgo || w_gap_go;

  assign w_drop_evt = w_tgo && !r_dcnt &&
                      (full || (w_tsel == 4'd1 && r_trunc));

  always_comb begin
    w_stat           = {2'b00, r_len};
    w_stat[ST_ERR]   = r_err;
    w_stat[ST_TRUNC] = r_trunc;
  end

  always_comb begin
    w_tag  = TAG_IDLE;
    w_mask = '0;
    w_data = '0;
    if (w_tgo) begin
      w_mask = '1;
      if (w_tsel == 4'd0) begin
        w_tag  = TAG_DATA;
        w_mask = w_pmask;
        w_data = w_part;
      end else if (w_tsel == 4'd1) begin
        w_tag                    = TAG_STAT;
        w_data[8*BYTES-1 -: 16] = w_stat;
      end else begin
        w_tag = TAG_TS;
        for (int j = 0; j < NTS; j++) begin
          if (w_tsel == 4'(j+2)) begin
            for (int k = 0; k < BYTES; k++) begin
              w_data[8*(BYTES-1-k) +: 8] = r_ts[8*(j*BYTES+k) +: 8];
            end
          end
        end
      end
    end else if (w_dword) begin
      w_tag  = TAG_DATA;
      w_mask = '1;
      w_data = w_pk_word;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) begin
      r_st    <= S_WAIT_IDLE;
      r_wr    <= 1'b0;
      r_din   <= '0;
      r_fc    <= '0;
      r_dc    <= '0;
      r_ts    <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_trunc <= 1'b0;
      r_dcnt  <= 1'b0;
      r_tidx  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_st <= w_nx;
      r_wr <= w_due && !full;
      if (w_due && !full) r_din <= {w_tag, w_mask, w_data};
      if (w_sfd) begin
        r_ts    <= global_counter;
        r_len   <= '0;
        r_err   <= 1'b0;
        r_trunc <= 1'b0;
        r_dcnt  <= 1'b0;
        r_fc    <= r_fc + 1'b1;
      end
      if (w_pk_vld) begin
        if (r_len != LEN_MAX) r_len <= r_len + 14'd1;
        if (gmii_rx_er)       r_err <= 1'b1;
      end
      if (w_lost) r_trunc <= 1'b1;
      if (w_drop_evt) begin
        r_dc   <= r_dc + 1'b1;
        r_dcnt <= 1'b1;
      end
      if (w_tgo) r_tidx <= w_tsel + 4'd1;
      r_gcnt <= w_gap_go ? r_gcnt + 3'd1 : 3'd0;
    end
  end

endmodule
